bram_stream_reader: RTL and testbench

- Port-B read engine for the dual-port block RAM: given a base address and word count, reads the memory range through one BRAM port and streams the words out on a valid/ready interface.
- Counterpart to the port-A writer that fills the memory.
- Absorbs the BRAM read latency and downstream backpressure with a small credit-controlled FIFO.
- Sustains 1 word/cycle while the consumer is ready.

---
 rtl/bram_stream_reader.sv | 227 ++++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ==========================================================================
// Module   : bram_stream_reader
// Purpose  : Port-B BRAM range reader streaming words out over valid/ready.
// Revision : 1.0 - initial release
// ==========================================================================
module bram_stream_reader #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int RD_LAT     = 1,
    parameter int ADDR_STEP  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clkb,
    input  logic                rstb,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   addrb,
    output logic                enb,
    output logic [DATA_W/8-1:0] web,
    output logic [DATA_W-1:0]   dinb,
    input  logic [DATA_W-1:0]   doutb,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last
);

    localparam int c_PW    = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_READ  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_addrb;
    logic              r_enb;
    logic              r_enb_last;
    logic [CNT_W-1:0]  r_remain;
    logic [RD_LAT-1:0] r_vpipe;
    logic [RD_LAT-1:0] r_lpipe;

    logic [DATA_W-1:0] r_mem_d [FIFO_DEPTH];
    logic              r_mem_l [FIFO_DEPTH];
    logic [c_PW-1:0]   r_wptr;
    logic [c_PW-1:0]   r_rptr;
    logic [c_PW:0]     r_fcnt;
    logic [DATA_W-1:0] r_m_data;
    logic              r_m_valid;
    logic              r_m_last;

    logic [1:0]         w_state_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [ADDR_W-1:0]  w_addrb_nxt;
    logic               w_enb_nxt;
    logic               w_enb_last_nxt;
    logic [CNT_W-1:0]   w_remain_nxt;
    logic [c_OCC_W-1:0] w_inflight;
    logic [c_OCC_W-1:0] w_occ;
    logic               w_credit_ok;
    logic               w_push;
    logic               w_push_last;
    logic               w_pop;
    logic               w_load;
    logic               w_fifo_wr;
    logic               w_fifo_rd;

    assign busy    = r_busy;
    assign done    = r_done;
    assign addrb   = r_addrb;
    assign enb     = r_enb;
    assign web     = '0;
    assign dinb    = '0;
    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign m_last  = r_m_last;

    assign w_push      = r_vpipe[RD_LAT-1];
    assign w_push_last = r_lpipe[RD_LAT-1];
    assign w_pop       = r_m_valid & m_ready;
    assign w_load      = ~r_m_valid | w_pop;
    assign w_fifo_rd   = w_load & (r_fcnt != '0);
    assign w_fifo_wr   = w_push & ~(w_load & (r_fcnt == '0));
    assign w_occ       = c_OCC_W'(r_fcnt) + c_OCC_W'(r_m_valid);

    // A slot freed by this cycle's pop is counted as credit; the new read lands later.
    always_comb begin
        w_inflight = c_OCC_W'(r_enb);
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + c_OCC_W'(r_vpipe[i]);
        end
        w_credit_ok = (w_inflight + w_occ - c_OCC_W'(w_pop)) < c_OCC_W'(FIFO_DEPTH);
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_addrb_nxt    = r_addrb;
        w_enb_nxt      = 1'b0;
        w_enb_last_nxt = 1'b0;
        w_remain_nxt   = r_remain;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_enb_nxt      = 1'b1;
                        w_enb_last_nxt = (count == CNT_W'(1));
                        w_addrb_nxt    = base_addr;
                        w_remain_nxt   = count - CNT_W'(1);
                        w_busy_nxt     = 1'b1;
                        w_state_nxt    = (count == CNT_W'(1)) ? c_DRAIN : c_READ;
                    end
                end
            end
            c_READ: begin
                if (w_credit_ok) begin
                    w_enb_nxt      = 1'b1;
                    w_enb_last_nxt = (r_remain == CNT_W'(1));
                    w_addrb_nxt    = r_addrb + ADDR_W'(ADDR_STEP);
                    w_remain_nxt   = r_remain - CNT_W'(1);
                    if (r_remain == CNT_W'(1)) begin
                        w_state_nxt = c_DRAIN;
                    end
                end
            end
            c_DRAIN: begin
                if (w_pop && r_m_last) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            r_state    <= c_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_addrb    <= '0;
            r_enb      <= 1'b0;
            r_enb_last <= 1'b0;
            r_remain   <= '0;
            r_vpipe    <= '0;
            r_lpipe    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_addrb    <= w_addrb_nxt;
            r_enb      <= w_enb_nxt;
            r_enb_last <= w_enb_last_nxt;
            r_remain   <= w_remain_nxt;
            r_vpipe[0] <= r_enb;
            r_lpipe[0] <= r_enb_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
                r_lpipe[i] <= r_lpipe[i-1];
            end
        end
    end

    always_ff @(posedge clkb) begin
        if (w_fifo_wr) begin
            r_mem_d[r_wptr] <= doutb;
            r_mem_l[r_wptr] <= w_push_last;
        end
    end

    // Output register is the FIFO head; words bypass the array only when it is empty.
    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_fcnt    <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            if (w_fifo_wr) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_fifo_rd) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            case ({w_fifo_wr, w_fifo_rd})
                2'b10:   r_fcnt <= r_fcnt + (c_PW+1)'(1);
                2'b01:   r_fcnt <= r_fcnt - (c_PW+1)'(1);
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_load) begin
                if (r_fcnt != '0) begin
                    r_m_data  <= r_mem_d[r_rptr];
                    r_m_last  <= r_mem_l[r_rptr];
                    r_m_valid <= 1'b1;
                end else if (w_push) begin
                    r_m_data  <= doutb;
                    r_m_last  <= w_push_last;
                    r_m_valid <= 1'b1;
                end else begin
                    r_m_last  <= 1'b0;
                    r_m_valid <= 1'b0;
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clkb) disable iff (rstb)
        !(w_push && !w_pop && (w_occ == c_OCC_W'(FIFO_DEPTH))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ==========================================================================
// Module   : tb_bram_stream_reader
// Purpose  : Directed self-checking bench for bram_stream_reader.
// Revision : 1.0 - initial release
// ==========================================================================
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] count;
    logic        busy, done, enb, m_valid, m_last;
    logic        m_ready;
    logic [31:0] addrb, dinb, doutb, m_data;
    logic [3:0]  web;
    logic [31:0] st1;

    logic        b_start;
    logic [7:0]  b_base;
    logic [15:0] b_count;
    logic        b_busy, b_done, b_enb, b_m_valid, b_m_last;
    wire         b_m_ready = 1'b1;
    logic [7:0]  b_addrb;
    logic [3:0]  b_web;
    logic [31:0] b_dinb, b_doutb, b_m_data, b_st1, b_st2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int start_edge;
    int rdy_mode = 0;
    logic [3:0] pat = 4'b1001;
    logic mon_clr = 1'b0;

    logic [31:0] rx_d[$];
    bit          rx_l[$];
    logic [31:0] addr_q[$];
    int enb_cnt, hs_cnt, done_cnt, done_cyc, first_v, first_hs, last_hs;
    int busy_seen, stall_err, max_out;
    bit prev_stall;
    logic [31:0] prev_d;
    bit prev_l;

    logic [31:0] b_rx_d[$];
    bit          b_rx_l[$];
    logic [7:0]  b_addr_q[$];
    int b_done_cnt, b_first_v;
    int exp_a[4];

    bram_stream_reader u_dut (
        .clkb(clk), .rstb(rst), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .addrb(addrb), .enb(enb), .web(web), .dinb(dinb),
        .doutb(doutb), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    bram_stream_reader #(.ADDR_W(8), .RD_LAT(2)) u_dut2 (
        .clkb(clk), .rstb(rst), .start(b_start), .base_addr(b_base), .count(b_count),
        .busy(b_busy), .done(b_done), .addrb(b_addrb), .enb(b_enb), .web(b_web), .dinb(b_dinb),
        .doutb(b_doutb), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_last(b_m_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: word at address a is a*3 (latency 1) and a*7+11 (latency 2).
    always @(posedge clk) begin
        if (enb) st1 <= addrb * 32'd3;
        if (b_enb) b_st1 <= {24'd0, b_addrb} * 32'd7 + 32'd11;
        b_st2 <= b_st1;
    end
    assign doutb   = st1;
    assign b_doutb = b_st2;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (rdy_mode != 0) ? pat[cyc % 4] : 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_clr) begin
                rx_d.delete(); rx_l.delete(); addr_q.delete();
                b_rx_d.delete(); b_rx_l.delete(); b_addr_q.delete();
                enb_cnt = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1;
                first_v = -1; first_hs = -1; last_hs = -1;
                busy_seen = 0; stall_err = 0; max_out = 0; prev_stall = 0;
                b_done_cnt = 0; b_first_v = -1;
            end else begin
                if (enb) begin addr_q.push_back(addrb); enb_cnt++; end
                if (enb_cnt - hs_cnt > max_out) max_out = enb_cnt - hs_cnt;
                if (busy) busy_seen = 1;
                if (m_valid && first_v < 0) first_v = cyc;
                if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stall_err++;
                prev_stall = m_valid && !m_ready;
                prev_d = m_data;
                prev_l = m_last;
                if (m_valid && m_ready) begin
                    rx_d.push_back(m_data);
                    rx_l.push_back(m_last);
                    if (first_hs < 0) first_hs = cyc;
                    if (m_last) last_hs = cyc;
                    hs_cnt++;
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (b_enb) b_addr_q.push_back(b_addrb);
                if (b_m_valid && b_first_v < 0) b_first_v = cyc;
                if (b_m_valid && b_m_ready) begin b_rx_d.push_back(b_m_data); b_rx_l.push_back(b_m_last); end
                if (b_done) b_done_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk);
        #1 mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic start_burst(input logic [31:0] base, input logic [15:0] n);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = base; count = n;
        start_edge = cyc + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            #1 k++;
        end
        repeat (3) begin @(negedge clk); #1; end
        check({tag, "_done"}, done_cnt, 1);
    endtask

    task automatic verify(input int base, input int n, input string tag);
        int derr = 0, aerr = 0, nlast = 0;
        check({tag, "_len"}, rx_d.size(), n);
        check({tag, "_naddr"}, addr_q.size(), n);
        for (int i = 0; i < rx_d.size(); i++) begin
            if (rx_d[i] !== 32'((base + i) * 3)) derr++;
            if (rx_l[i]) nlast++;
        end
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 32'(base + i)) aerr++;
        check({tag, "_data_err"}, derr, 0);
        check({tag, "_addr_err"}, aerr, 0);
        check({tag, "_nlast"}, nlast, 1);
        check({tag, "_last_pos"}, (rx_l.size() == n && n > 0) ? rx_l[n-1] : 1'b0, 1);
        check({tag, "_done_lat"}, done_cyc - last_hs, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        b_start = 1'b0; b_base = '0; b_count = '0;
        exp_a[0] = 254; exp_a[1] = 255; exp_a[2] = 0; exp_a[3] = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_enb", enb, 0);
        check("rst_addrb", addrb, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_b_m_valid", b_m_valid, 0);
        check("web_dinb", {web, dinb}, 0);
        rst = 1'b0;

        // Basic burst, consumer always ready.
        clear_mon();
        start_burst(32'd1, 16'd100);
        wait_done(400, "basic");
        verify(1, 100, "basic");
        check("basic_first_lat", first_v - start_edge, 2);
        check("basic_b2b", last_hs - first_hs, 99);
        check("basic_busy_end", busy, 0);

        // Backpressure with ready pattern 1,0,0,1.
        rdy_mode = 1;
        clear_mon();
        start_burst(32'd10, 16'd16);
        wait_done(400, "bp");
        verify(10, 16, "bp");
        check("bp_stall_err", stall_err, 0);
        check("bp_max_out", max_out, 4);
        rdy_mode = 0;

        // count = 0 and count = 1.
        clear_mon();
        start_burst(32'd7, 16'd0);
        wait_done(20, "zero");
        check("zero_done_lat", done_cyc - start_edge, 0);
        check("zero_enb", enb_cnt, 0);
        check("zero_busy", busy_seen, 0);
        clear_mon();
        start_burst(32'd5, 16'd1);
        wait_done(20, "one");
        verify(5, 1, "one");

        // Latency 2 with 8-bit address wrap.
        clear_mon();
        @(posedge clk);
        #1;
        b_start = 1'b1; b_base = 8'd254; b_count = 16'd4;
        start_edge = cyc + 1;
        @(posedge clk);
        #1 b_start = 1'b0;
        k = 0;
        while (b_done_cnt == 0 && k < 50) begin @(negedge clk); #1 k++; end
        repeat (3) begin @(negedge clk); #1; end
        check("wrap_done", b_done_cnt, 1);
        check("wrap_first_lat", b_first_v - start_edge, 3);
        check("wrap_naddr", b_addr_q.size(), 4);
        check("wrap_len", b_rx_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_addr%0d", i), (b_addr_q.size() > i) ? b_addr_q[i] : 8'hxx, exp_a[i]);
            check($sformatf("wrap_data%0d", i), (b_rx_d.size() > i) ? b_rx_d[i] : 32'hx, exp_a[i] * 7 + 11);
        end
        check("wrap_last", (b_rx_l.size() == 4) ? b_rx_l[3] : 1'b0, 1);

        // Start pulses during READ and DRAIN are ignored.
        clear_mon();
        start_burst(32'd50, 16'd8);
        repeat (2) @(posedge clk);
        #1 begin start = 1'b1; base_addr = 32'd900; count = 16'd2; end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100, "ign");
        verify(50, 8, "ign");

        // Reset after word 5 of 20, then a fresh burst.
        clear_mon();
        start_burst(32'd300, 16'd20);
        k = 0;
        while (hs_cnt < 5 && k < 100) begin @(negedge clk); #1 k++; end
        check("rst_reach5", hs_cnt >= 5, 1);
        #1 rst = 1'b1;
        #1;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_enb", enb, 0);
        check("midrst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin @(negedge clk); #1; end
        check("midrst_no_done", done_cnt, 0);
        clear_mon();
        start_burst(32'd0, 16'd3);
        wait_done(50, "post");
        verify(0, 3, "post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
